// File: rtl/register_tree_sift_up_if.sv
// Push/pop handshake bundle for the register-tree min-priority queue.
interface register_tree_sift_up_if #(
    parameter int unsigned TREE_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned NUM_NODES = (1 << TREE_DEPTH) - 1;
    localparam int unsigned CNT_W     = $clog2(NUM_NODES + 1);

    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;

    // Producer/consumer side of the queue
    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, count, full, empty
    );

    // Queue side
    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, count, full, empty
    );
endinterface

// File: rtl/register_tree_sift_up.sv
// Min-priority queue stored as a binary heap in flops. Pushes enter at the
// first free slot and sift up one level per cycle; pops move the last item to
// the root and sift down one level per cycle; push+pop replaces the root.
module register_tree_sift_up #(
    parameter int unsigned TREE_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    register_tree_sift_up_if.slave  bus
);
    localparam int unsigned NUM_NODES = (1 << TREE_DEPTH) - 1;
    localparam int unsigned CNT_W     = $clog2(NUM_NODES + 1);
    // one extra bit so 2*i+2 never wraps
    localparam int unsigned IDX_W     = CNT_W + 1;
    localparam logic [DATA_WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_tree [NUM_NODES];
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_cur;

    logic                  w_idle;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_fire;
    logic                  w_pop_fire;
    logic [CNT_W-1:0]      w_parent;
    logic [IDX_W-1:0]      w_left;
    logic [IDX_W-1:0]      w_right;
    logic                  w_has_l;
    logic                  w_has_r;
    logic [CNT_W-1:0]      w_left_idx;
    logic [CNT_W-1:0]      w_right_idx;
    logic [CNT_W-1:0]      w_child;
    logic                  w_child_leaf;
    logic                  w_up_swap;
    logic                  w_down_swap;

    assign w_idle      = (r_state == IDLE);
    assign w_full      = (r_count == CNT_W'(NUM_NODES));
    assign w_empty     = (r_count == '0);
    assign w_push_fire = bus.push_valid && w_idle && !w_full;
    assign w_pop_fire  = bus.pop_ready && w_idle && !w_empty;

    // Neighbourhood of the node being moved
    assign w_parent     = (r_cur - CNT_W'(1)) >> 1;
    assign w_left       = {r_cur, 1'b1};
    assign w_right      = w_left + IDX_W'(1);
    assign w_has_l      = (w_left < {1'b0, r_count});
    assign w_has_r      = (w_right < {1'b0, r_count});
    // occupied children always fit in CNT_W; park the index at 0 otherwise
    assign w_left_idx   = w_has_l ? CNT_W'(w_left) : '0;
    assign w_right_idx  = w_has_r ? CNT_W'(w_right) : '0;
    assign w_child      = (w_has_r && (r_tree[w_right_idx] < r_tree[w_left_idx]))
                          ? w_right_idx : w_left_idx;
    // child with no occupied children of its own ends the descent
    assign w_child_leaf = ({w_child, 1'b1} >= {1'b0, r_count});
    assign w_up_swap    = (r_tree[r_cur] < r_tree[w_parent]);
    assign w_down_swap  = w_has_l && (r_tree[w_child] < r_tree[r_cur]);

    assign bus.push_ready = w_idle && !w_full;
    assign bus.pop_valid  = w_idle && !w_empty;
    assign bus.pop_data   = r_tree[0];
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: start a sift on accepted operations, stop when the item settles
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_push_fire && w_pop_fire) begin
                    w_next_state = (r_count > CNT_W'(1)) ? SIFT_DOWN : IDLE;
                end else if (w_push_fire) begin
                    w_next_state = (r_count != '0) ? SIFT_UP : IDLE;
                end else if (w_pop_fire) begin
                    w_next_state = (r_count > CNT_W'(2)) ? SIFT_DOWN : IDLE;
                end
            end
            SIFT_UP: begin
                if (!w_up_swap || (w_parent == '0)) begin
                    w_next_state = IDLE;
                end
            end
            SIFT_DOWN: begin
                if (!w_down_swap || w_child_leaf) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Heap storage, occupancy and cursor updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NODES); i++) begin
                r_tree[i] <= MAX;
            end
            r_count <= '0;
            r_cur   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push_fire && w_pop_fire) begin
                        r_tree[0] <= bus.push_data;
                        r_cur     <= '0;
                    end else if (w_push_fire) begin
                        r_tree[r_count] <= bus.push_data;
                        r_cur           <= r_count;
                        r_count         <= r_count + CNT_W'(1);
                    end else if (w_pop_fire) begin
                        // with one item both writes hit slot 0; MAX must win
                        r_tree[0]                   <= r_tree[r_count - CNT_W'(1)];
                        r_tree[r_count - CNT_W'(1)] <= MAX;
                        r_count                     <= r_count - CNT_W'(1);
                        r_cur                       <= '0;
                    end
                end
                SIFT_UP: begin
                    if (w_up_swap) begin
                        r_tree[r_cur]    <= r_tree[w_parent];
                        r_tree[w_parent] <= r_tree[r_cur];
                        r_cur            <= w_parent;
                    end
                end
                SIFT_DOWN: begin
                    if (w_down_swap) begin
                        r_tree[r_cur]   <= r_tree[w_child];
                        r_tree[w_child] <= r_tree[r_cur];
                        r_cur           <= w_child;
                    end
                end
                default: begin
                    r_cur <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_register_tree_sift_up.sv
// Self-checking bench for register_tree_sift_up: directed scenarios plus a
// randomized push/pop run against a queue-based minimum model.
module tb_register_tree_sift_up;
    localparam int unsigned TREE_DEPTH = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_NODES  = (1 << TREE_DEPTH) - 1;
    localparam int unsigned CNT_W      = $clog2(NUM_NODES + 1);
    localparam logic [DATA_WIDTH-1:0] MAX = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_tree_sift_up_if #(.TREE_DEPTH(TREE_DEPTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    register_tree_sift_up #(.TREE_DEPTH(TREE_DEPTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Wait (bounded) until a push would be accepted
    task automatic wait_push_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.push_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_ready_timeout got 0 exp 1");
        end
    endtask

    // Wait (bounded) until a pop would be accepted
    task automatic wait_pop_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.pop_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL pop_valid_timeout got 0 exp 1");
        end
    endtask

    // Wait (bounded) until the queue is idle again
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.push_ready === 1'b1 || bus.pop_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout got busy exp idle");
        end
    endtask

    task automatic do_push(input logic [DATA_WIDTH-1:0] d);
        bit ok;
        wait_push_ready(ok);
        if (ok) begin
            bus.push_valid = 1'b1;
            bus.push_data  = d;
            @(posedge clk);
            #1;
            bus.push_valid = 1'b0;
        end
    endtask

    task automatic do_pop(output logic [DATA_WIDTH-1:0] d);
        bit ok;
        d = 'x;
        wait_pop_valid(ok);
        if (ok) begin
            d = bus.pop_data;
            bus.pop_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.pop_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.push_ready !== 1'b1 ||
            bus.pop_valid !== 1'b0 || bus.full !== 1'b0 || bus.pop_data !== MAX) begin
            errors++;
            $display("FAIL reset_initial got cnt=%0d empty=%b full=%b pr=%b pv=%b pd=%0h exp cnt=0 empty=1 full=0 pr=1 pv=0 pd=%0h",
                     bus.count, bus.empty, bus.full, bus.push_ready, bus.pop_valid, bus.pop_data, MAX);
        end
        rst_n = 1'b1;
        do_push(40);
        do_push(30);
        do_push(20);
        do_push(5);
        // mid sift-up of 5: async reset must clear at once
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.push_ready !== 1'b1 ||
            bus.pop_valid !== 1'b0 || bus.pop_data !== MAX) begin
            errors++;
            $display("FAIL reset_async got cnt=%0d empty=%b pr=%b pv=%b pd=%0h exp cnt=0 empty=1 pr=1 pv=0 pd=%0h",
                     bus.count, bus.empty, bus.push_ready, bus.pop_valid, bus.pop_data, MAX);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.push_ready !== 1'b1 || bus.pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got cnt=%0d empty=%b pr=%b pv=%b exp cnt=0 empty=1 pr=1 pv=0",
                     bus.count, bus.empty, bus.push_ready, bus.pop_valid);
        end
    endtask

    task automatic test_basic();
        logic [DATA_WIDTH-1:0] vals[4] = '{50, 30, 40, 10};
        logic [DATA_WIDTH-1:0] exp_order[4] = '{10, 30, 40, 50};
        logic [DATA_WIDTH-1:0] d;
        foreach (vals[i]) do_push(vals[i]);
        wait_idle();
        checks++;
        if (bus.pop_data !== 10 || bus.count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL basic_root got pd=%0d cnt=%0d exp pd=10 cnt=4", bus.pop_data, bus.count);
        end
        foreach (exp_order[i]) begin
            do_pop(d);
            checks++;
            if (d !== exp_order[i]) begin
                errors++;
                $display("FAIL basic_pop%0d got %0d exp %0d", i, d, exp_order[i]);
            end
        end
    endtask

    task automatic test_full();
        logic [DATA_WIDTH-1:0] d;
        for (int v = 150; v >= 10; v -= 10) do_push(DATA_WIDTH'(v));
        wait_idle();
        checks++;
        if (bus.full !== 1'b1 || bus.push_ready !== 1'b0 || bus.count !== CNT_W'(NUM_NODES)) begin
            errors++;
            $display("FAIL full_flags got full=%b pr=%b cnt=%0d exp full=1 pr=0 cnt=%0d",
                     bus.full, bus.push_ready, bus.count, NUM_NODES);
        end
        bus.push_valid = 1'b1;
        bus.push_data  = 5;
        repeat (3) @(negedge clk);
        bus.push_valid = 1'b0;
        checks++;
        if (bus.count !== CNT_W'(NUM_NODES) || bus.pop_data !== 10) begin
            errors++;
            $display("FAIL full_held_push got cnt=%0d pd=%0d exp cnt=%0d pd=10", bus.count, bus.pop_data, NUM_NODES);
        end
        for (int v = 10; v <= 150; v += 10) begin
            do_pop(d);
            checks++;
            if (d !== DATA_WIDTH'(v)) begin
                errors++;
                $display("FAIL full_pop got %0d exp %0d", d, v);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== '0) begin
            errors++;
            $display("FAIL full_drain got empty=%b cnt=%0d exp empty=1 cnt=0", bus.empty, bus.count);
        end
    endtask

    task automatic test_push_pop();
        logic [DATA_WIDTH-1:0] exp_order[3] = '{20, 25, 30};
        logic [DATA_WIDTH-1:0] d;
        bit ok;
        do_push(10);
        do_push(20);
        do_push(30);
        wait_pop_valid(ok);
        if (ok) begin
            checks++;
            if (bus.push_ready !== 1'b1 || bus.pop_data !== 10) begin
                errors++;
                $display("FAIL pushpop_pre got pr=%b pd=%0d exp pr=1 pd=10", bus.push_ready, bus.pop_data);
            end
            bus.push_valid = 1'b1;
            bus.push_data  = 25;
            bus.pop_ready  = 1'b1;
            @(posedge clk);
            #1;
            bus.push_valid = 1'b0;
            bus.pop_ready  = 1'b0;
        end
        wait_idle();
        checks++;
        if (bus.count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL pushpop_count got %0d exp 3", bus.count);
        end
        foreach (exp_order[i]) begin
            do_pop(d);
            checks++;
            if (d !== exp_order[i]) begin
                errors++;
                $display("FAIL pushpop_pop%0d got %0d exp %0d", i, d, exp_order[i]);
            end
        end
    endtask

    task automatic test_equal();
        logic [DATA_WIDTH-1:0] d;
        repeat (3) do_push(7);
        repeat (3) begin
            do_pop(d);
            checks++;
            if (d !== 7) begin
                errors++;
                $display("FAIL equal_pop got %0d exp 7", d);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1 || bus.pop_data !== MAX || bus.pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL equal_empty got empty=%b pd=%0h pv=%b exp empty=1 pd=%0h pv=0",
                     bus.empty, bus.pop_data, bus.pop_valid, MAX);
        end
    endtask

    task automatic test_random();
        logic [DATA_WIDTH-1:0] model[$];
        logic [DATA_WIDTH-1:0] d;
        logic [DATA_WIDTH-1:0] mn;
        int  mi;
        int  busy;
        int  bad_slot;
        bit  idle, pv, pr, fire_push, fire_pop, phase;
        busy = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            checks++;
            if (bus.count !== CNT_W'(model.size())) begin
                errors++;
                $display("FAIL rand_count cyc=%0d got %0d exp %0d", cyc, bus.count, model.size());
            end
            bad_slot = -1;
            for (int i = model.size(); i < int'(NUM_NODES); i++) begin
                if (dut.r_tree[i] !== MAX && bad_slot < 0) bad_slot = i;
            end
            checks++;
            if (bad_slot >= 0) begin
                errors++;
                $display("FAIL rand_free_slot cyc=%0d slot=%0d got %0h exp %0h",
                         cyc, bad_slot, dut.r_tree[bad_slot], MAX);
            end
            idle = (bus.push_ready === 1'b1) || (bus.pop_valid === 1'b1);
            mi = -1;
            if (idle) begin
                busy = 0;
                checks++;
                if (bus.pop_valid !== (model.size() != 0) || bus.push_ready !== (model.size() != NUM_NODES)) begin
                    errors++;
                    $display("FAIL rand_handshake cyc=%0d got pv=%b pr=%b exp pv=%b pr=%b", cyc,
                             bus.pop_valid, bus.push_ready, model.size() != 0, model.size() != NUM_NODES);
                end
                if (model.size() != 0) begin
                    mi = 0;
                    mn = model[0];
                    foreach (model[k]) if (model[k] < mn) begin mn = model[k]; mi = k; end
                    checks++;
                    if (bus.pop_data !== mn) begin
                        errors++;
                        $display("FAIL rand_min cyc=%0d got %0d exp %0d", cyc, bus.pop_data, mn);
                    end
                end
            end else begin
                busy++;
                checks++;
                if (busy > int'(TREE_DEPTH) - 1) begin
                    errors++;
                    $display("FAIL rand_busy cyc=%0d got %0d exp <=%0d", cyc, busy, TREE_DEPTH - 1);
                end
            end
            phase = ((cyc / 400) % 2) == 1;
            pv = $urandom_range(0, 99) < (phase ? 30 : 70);
            pr = $urandom_range(0, 99) < (phase ? 70 : 30);
            d  = ($urandom_range(0, 3) == 0) ? DATA_WIDTH'($urandom >> 1) : DATA_WIDTH'($urandom_range(0, 40));
            bus.push_valid = pv;
            bus.push_data  = d;
            bus.pop_ready  = pr;
            fire_push = pv && (bus.push_ready === 1'b1);
            fire_pop  = pr && (bus.pop_valid === 1'b1) && (mi >= 0);
            @(posedge clk);
            if (fire_pop) model.delete(mi);
            if (fire_push) model.push_back(d);
        end
        @(negedge clk);
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_push_pop();
        test_equal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
